// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    FINISH
  } ccff_state_e;

  localparam int unsigned ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_SAT = '1;

endpackage

// File: rtl/ccff_piso.sv
// Word-wide parallel-in/serial-out register; head holds the bit currently driven to the chain.
module ccff_piso #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned WL_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic [WL_W-1:0]   load_cnt,
  output logic              head,
  output logic [WL_W-1:0]   word_left
);

  logic [WORD_W-1:0] sreg;

  // On load the MSB goes straight to head so the first shift cycle follows the fetch edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      head      <= 1'b0;
      word_left <= '0;
    end else if (load) begin
      head      <= data[WORD_W-1];
      sreg      <= WORD_W'(data << 1);
      word_left <= load_cnt;
    end else if (shift) begin
      head      <= sreg[WORD_W-1];
      sreg      <= WORD_W'(sreg << 1);
      word_left <= word_left - WL_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto a configuration chain and optionally verifies the chain tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 80,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset_n,
  input  logic                 start,
  input  logic                 verify,
  input  logic [WORD_W-1:0]    bs_data,
  input  logic                 bs_valid,
  output logic                 bs_ready,
  output logic                 ccff_head,
  output logic                 cfg_shift_en,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned WL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  ccff_state_e      state, state_n;
  logic [CNT_W-1:0] bit_cnt, cnt_n, cnt_base;
  logic [WL_W-1:0]  word_left, wl_n, load_cnt;
  logic [31:0]      rem;
  logic             load, shift, clr, accept, vmode;
  logic             ready_n, shift_en_n, busy_n, done_n;

  assign accept = bs_valid & bs_ready;

  // Next state plus look-ahead values for the registered handshake/enable outputs.
  always_comb begin
    state_n  = state;
    cnt_n    = bit_cnt;
    load     = 1'b0;
    shift    = 1'b0;
    clr      = 1'b0;
    cnt_base = (state == SHIFT) ? bit_cnt + CNT_W'(1) : bit_cnt;
    rem      = 32'(CHAIN_LEN) - 32'(cnt_base);
    load_cnt = (rem < 32'(WORD_W)) ? WL_W'(rem) : WL_W'(WORD_W);

    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          cnt_n   = '0;
          clr     = 1'b1;
        end
      end
      FETCH: begin
        if (accept) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // A SHIFT cycle with the count already full is the drain cycle before FINISH.
        if (bit_cnt == LEN_C) begin
          state_n = FINISH;
        end else begin
          shift = 1'b1;
          cnt_n = bit_cnt + CNT_W'(1);
          if (cnt_n != LEN_C && word_left == WL_W'(1)) begin
            if (accept) load = 1'b1;
            else        state_n = FETCH;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    wl_n       = load ? load_cnt : (shift ? word_left - WL_W'(1) : word_left);
    shift_en_n = (state_n == SHIFT) && (cnt_n != LEN_C);
    // Ready on the last bit of a word, but never on the final chain bit.
    ready_n    = (state_n == FETCH) ||
                 ((state_n == SHIFT) && (wl_n == WL_W'(1)) &&
                  (32'(cnt_n) + 32'd1 < 32'(CHAIN_LEN)));
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == FINISH);
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      vmode        <= 1'b0;
      bs_ready     <= 1'b0;
      cfg_shift_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= cnt_n;
      bs_ready     <= ready_n;
      cfg_shift_en <= shift_en_n;
      busy         <= busy_n;
      done         <= done_n;
      if (clr) vmode <= verify;
    end
  end

  // Tail is sampled before the shifting edge, so it holds the bit written by the previous pass.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (clr) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (cfg_shift_en && vmode && (ccff_tail != ccff_head)) begin
      mismatch <= 1'b1;
      if (err_cnt != ERR_SAT) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  ccff_piso #(
    .WORD_W (WORD_W),
    .WL_W   (WL_W)
  ) u_piso (
    .clk       (prog_clk),
    .rst_n     (pReset_n),
    .load      (load),
    .shift     (shift),
    .data      (bs_data),
    .load_cnt  (load_cnt),
    .head      (ccff_head),
    .word_left (word_left)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader on a 12-flop chain with 8-bit words.
module tb_ccff_chain_loader;

  localparam int unsigned LEN = 12;
  localparam int unsigned WW  = 8;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b0;
  logic          start    = 1'b0;
  logic          verify   = 1'b0;
  logic [WW-1:0] bs_data  = '0;
  logic          bs_valid = 1'b0;
  logic          bs_ready, ccff_head, cfg_shift_en, ccff_tail, busy, done, mismatch;
  logic [15:0]   err_cnt;

  logic [LEN-1:0] chain = '0;

  localparam logic [LEN-1:0] S_OK = 12'b1010_0101_0011;
  localparam logic [LEN-1:0] S_2C = 12'b1010_0101_0010;
  localparam logic [LEN-1:0] S_25 = 12'b0010_0101_0011;

  typedef struct {
    int          cyc;
    logic        mm;
    logic [15:0] err;
  } done_t;

  bit    head_q[$];
  done_t done_q[$];
  done_t mon_rec;
  bit    mon_bit;
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    shift_cnt = 0;
  int    cyc       = 0;

  ccff_chain_loader #(.CHAIN_LEN(LEN), .WORD_W(WW)) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .verify       (verify),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .ccff_head    (ccff_head),
    .cfg_shift_en (cfg_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .mismatch     (mismatch),
    .err_cnt      (err_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Chain model: shifts toward the tail on enabled edges.
  always @(posedge prog_clk) if (cfg_shift_en) chain <= {chain[LEN-2:0], ccff_head};
  assign ccff_tail = chain[LEN-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT shifts a bit or pulses done.
  always @(negedge prog_clk) begin
    if (!pReset_n) begin
      shift_cnt = 0;
    end else begin
      if (cfg_shift_en) begin
        check("shift_expected", 32'(head_q.size() != 0), 32'd1);
        if (head_q.size() != 0) begin
          mon_bit = head_q.pop_front();
          check("head_bit", 32'(ccff_head), 32'(mon_bit));
        end
        shift_cnt++;
      end
      if (done) begin
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          mon_rec = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_rec.cyc));
          check("done_mismatch", 32'(mismatch), 32'(mon_rec.mm));
          check("done_err_cnt", 32'(err_cnt), 32'(mon_rec.err));
          check("done_shifts", 32'(shift_cnt), LEN);
          check("done_busy", 32'(busy), 32'd1);
        end
        shift_cnt = 0;
      end
    end
  end

  task automatic start_pass(input logic v, input logic [LEN-1:0] stream, input int nbits,
                            input bit exp_done, input int lat, input logic mm,
                            input logic [15:0] err);
    @(posedge prog_clk); #1;
    start  = 1'b1;
    verify = v;
    for (int i = 0; i < nbits; i++) head_q.push_back(stream[LEN-1-i]);
    if (exp_done) done_q.push_back('{cyc + lat, mm, err});
    @(posedge prog_clk); #1;
    start  = 1'b0;
    verify = 1'b0;
    check("busy_fetch", 32'(busy), 32'd1);
    check("ready_fetch", 32'(bs_ready), 32'd1);
  endtask

  task automatic send_word(input logic [WW-1:0] d, input int gap);
    int k;
    if (gap > 0) begin
      k = 0;
      do begin @(negedge prog_clk); k++; end while (!bs_ready && k < 100);
      check("ready_before_gap", 32'(bs_ready), 32'd1);
      repeat (gap) @(posedge prog_clk);
      #1;
    end
    bs_valid = 1'b1;
    bs_data  = d;
    k = 0;
    do begin @(negedge prog_clk); k++; end while (!bs_ready && k < 100);
    check("accept_wait", 32'(bs_ready), 32'd1);
    @(posedge prog_clk); #1;
    bs_valid = 1'b0;
    bs_data  = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge prog_clk); k++; end while ((done_q.size() != 0 || busy) && k < 200);
    check("pass_end", 32'(done_q.size()), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("head_q_drained", 32'(head_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_head"}, 32'(ccff_head), 32'd0);
    check({tag, "_shift_en"}, 32'(cfg_shift_en), 32'd0);
    check({tag, "_ready"}, 32'(bs_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge prog_clk);
    #1;
    check_reset_outputs("rst");
    pReset_n = 1'b1;
    @(posedge prog_clk); #1;

    // Plain load A5,3C back to back.
    start_pass(1'b0, S_OK, 12, 1'b1, 15, 1'b0, 16'd0);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_idle();
    check("chain_load", 32'(chain), 32'(S_OK));

    // Verify with identical data.
    start_pass(1'b1, S_OK, 12, 1'b1, 15, 1'b0, 16'd0);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_idle();
    check("chain_verify_ok", 32'(chain), 32'(S_OK));

    // Verify with one flipped bit in the second word.
    start_pass(1'b1, S_2C, 12, 1'b1, 15, 1'b1, 16'd1);
    send_word(8'hA5, 0);
    send_word(8'h2C, 0);
    wait_idle();
    check("chain_verify_2c", 32'(chain), 32'(S_2C));

    // Load with a 3-cycle valid gap between words.
    start_pass(1'b0, S_OK, 12, 1'b1, 18, 1'b0, 16'd0);
    send_word(8'hA5, 0);
    send_word(8'h3C, 3);
    wait_idle();
    check("chain_stall", 32'(chain), 32'(S_OK));

    // Reset after five shifts, then a full reload.
    start_pass(1'b0, S_OK, 5, 1'b0, 0, 1'b0, 16'd0);
    send_word(8'hA5, 0);
    repeat (5) @(posedge prog_clk);
    #1;
    pReset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge prog_clk);
    #1;
    pReset_n = 1'b1;
    @(posedge prog_clk); #1;
    check("busy_after_rst", 32'(busy), 32'd0);
    check("head_q_after_rst", 32'(head_q.size()), 32'd0);
    start_pass(1'b0, S_OK, 12, 1'b1, 15, 1'b0, 16'd0);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    wait_idle();
    check("chain_reload", 32'(chain), 32'(S_OK));

    // Verify 25,3C against A5,3C with start pulses mid-pass and in FINISH.
    start_pass(1'b1, S_25, 12, 1'b1, 15, 1'b1, 16'd1);
    fork
      begin
        send_word(8'h25, 0);
        send_word(8'h3C, 0);
      end
      begin
        repeat (4) @(posedge prog_clk);
        #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("mismatch_mid", 32'(mismatch), 32'd1);
        check("err_cnt_mid", 32'(err_cnt), 32'd1);
        repeat (9) @(posedge prog_clk);
        #1;
        check("done_in_finish", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
      end
    join
    wait_idle();
    repeat (3) @(negedge prog_clk);
    check("busy_after_ignored_start", 32'(busy), 32'd0);
    check("mismatch_held", 32'(mismatch), 32'd1);
    check("chain_verify_25", 32'(chain), 32'(S_25));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader for the programmable logic tiles. It accepts bitstream words over a valid/ready interface and serializes them MSB-first onto the tile's `ccff_head`, one bit per enabled `prog_clk` cycle. An optional verify pass re-shifts the same bitstream and compares `ccff_tail` against it bit-for-bit. It sits between the bitstream source (JTAG/SPI bridge) and the head of the concatenated `ccff_head`→`ccff_tail` chain of a tile column.

## Interface
- `CHAIN_LEN`, default 80: number of configuration flops in the chain (≥ 2).
- `WORD_W`, default 8: bitstream word width (≥ 1).
- `CNT_W`, default $clog2(CHAIN_LEN+1): width of the bit counter.

Ports:
- `prog_clk` in 1: the single clock.
- `pReset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse; begins a pass. Ignored while `busy`.
- `verify` in 1: sampled with `start`; 1 = verify pass, 0 = load pass.
- `bs_data` in WORD_W: bitstream word; MSB is shifted first.
- `bs_valid` in 1: word valid.
- `bs_ready` out 1: word accepted on `bs_valid & bs_ready`.
- `ccff_head` out 1: registered serial data to the chain head.
- `cfg_shift_en` out 1: registered clock enable for the chain's `prog_clk` gate; the chain shifts on the edge that ends a cycle with `cfg_shift_en`=1.
- `ccff_tail` in 1: chain tail, the chain flop output.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at the end of a pass.
- `mismatch` out 1: sticky; a verify-pass compare failed.
- `err_cnt` out 16: number of mismatching bits in the last verify pass; saturates at 16'hFFFF.

## Operation
- States: IDLE, FETCH, SHIFT, FINISH.
- IDLE: `start` → FETCH. Clears `bit_cnt`, `mismatch` and `err_cnt`, and latches `verify` into `vmode`.
- FETCH: `bs_ready`=1. On acceptance, the word is loaded into the shift register, `word_left`=min(WORD_W, CHAIN_LEN−`bit_cnt`), state → SHIFT.
- SHIFT: each cycle drives the shift-register MSB to `ccff_head`, sets `cfg_shift_en`=1, shifts left, increments `bit_cnt` and decrements `word_left`.
  - On the last bit of the word, `bs_ready`=1. If a word is accepted in that same cycle, SHIFT continues with no bubble; otherwise → FETCH.
  - When `bit_cnt` reaches CHAIN_LEN → FINISH. Any remaining low-order bits of the final word are discarded.
- FINISH: pulses `done` for one cycle, then → IDLE.
- Verify (`vmode`=1):
  - In every shift cycle, compare `ccff_tail` (sampled before the shifting edge) with the bit being driven on `ccff_head`.
  - On inequality: set `mismatch`, increment `err_cnt` (saturating).
  - Load passes do not compare and do not update `mismatch` or `err_cnt`.
- A verify pass rewrites the chain with the same data, so the chain contents are unchanged on success.
- `start` while `busy` is ignored. A `start` in the FINISH cycle is also ignored.
- `bs_valid` low in FETCH: no shift; the chain holds its contents.

## Timing
- Reset values: `ccff_head`=0, `cfg_shift_en`=0, `bs_ready`=0, `busy`=0, `done`=0, `mismatch`=0, `err_cnt`=0, state IDLE.
- Cycle timeline for a pass:
  - `start` in cycle t.
  - FETCH in cycle t+1, where `bs_ready`=1.
  - With the word accepted in t+1, the first `cfg_shift_en`=1 is in t+2.
- With no stalls, a pass takes CHAIN_LEN+3 cycles from `start` to `done`. `busy`=1 from t+1 through the `done` cycle.
- `mismatch` and `err_cnt` update one cycle after the compared shift cycle. Both are final in the `done` cycle.
- Reset mid-pass:
  - Immediate return to IDLE, with no `done` pulse.
  - Chain contents are undefined; a full load is required afterwards.
- Bit order: the first bit shifted ends up at the flop nearest `ccff_tail`.

## Structure
- Package `ccff_loader_pkg`:
  - `ccff_state_e` enum.
  - `ERR_CNT_W`=16.
  - Saturation constant.
- Sub-module `ccff_piso`: WORD_W parallel-in/serial-out register with load, shift and `word_left` count.
- The top level holds the FSM, `bit_cnt` and the compare/error logic.

## Test plan
1. Load pass with CHAIN_LEN=12, WORD_W=8, words 8'hA5, 8'h3C → head bits 1,0,1,0,0,1,0,1,0,0,1,1 on 12 consecutive `cfg_shift_en` cycles. Low nibble of 8'h3C discarded, `done` at t+15, chain model equals the stream.
2. Verify pass after test 1 with the same words → `mismatch`=0, `err_cnt`=0, chain unchanged.
3. Verify pass with the second word 8'h2C → exactly 1 mismatch; `mismatch`=1, `err_cnt`=1 at `done`.
4. `bs_valid` deasserted for 3 cycles between words → `cfg_shift_en` low for those cycles, no extra shifts, 12 shifts total, `done` delayed by 3.
5. `pReset_n` low after 5 shifts → all outputs at reset values asynchronously. A new `start` performs a full 12-bit load.
6. `start` pulsed at shift 4 and in the FINISH cycle → ignored; one `done` only, `mismatch`/`err_cnt` not cleared mid-pass.
